// File: rtl/window_stream_gen.sv
// Sliding-window generator: streams a raster-ordered image from 1-cycle-latency BRAM and
// emits KxK pixel windows (runtime W/H/K, stride 1 or 2) with valid/ready backpressure.
module window_stream_gen #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned MAX_IMG_WIDTH   = 28,
    parameter int unsigned MAX_KERNEL_SIZE = 5,
    parameter int unsigned DIM_W           = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_W-1:0]      img_width,
    input  logic [DIM_W-1:0]      img_height,
    input  logic [2:0]            ker_size,
    input  logic                  stride,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_din,
    output logic [MAX_KERNEL_SIZE-1:0][MAX_KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [DIM_W-1:0]      win_row,
    output logic [DIM_W-1:0]      win_col,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err
);
    localparam int unsigned KS    = MAX_KERNEL_SIZE;
    localparam int unsigned NLB   = MAX_KERNEL_SIZE - 1;
    localparam int unsigned PIX_W = 2 * DIM_W;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_t;

    state_t                state_q;
    logic [DIM_W-1:0]      cfg_w_q;
    logic [2:0]            cfg_k_q;
    logic                  cfg_s_q;
    logic [DIM_W-1:0]      last_row_q;
    logic [DIM_W-1:0]      last_col_q;
    logic [PIX_W-1:0]      npix_m1_q;
    logic [PIX_W-1:0]      iss_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_vld_q;
    logic                  hold_vld_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  done_seen_q;
    logic [DIM_W-1:0]      proc_row_q;
    logic [DIM_W-1:0]      proc_col_q;
    logic [DATA_WIDTH-1:0] lb_q [NLB][MAX_IMG_WIDTH];
    logic [KS-1:0][KS-1:0][DATA_WIDTH-1:0] tap_q;
    logic [KS-1:0][KS-1:0][DATA_WIDTH-1:0] tap_d;
    logic [KS-1:0][DATA_WIDTH-1:0]         colv;

    logic                  stall;
    logic                  issue;
    logic                  pix_vld;
    logic                  consume;
    logic                  emit;
    logic                  cfg_ok;
    logic                  last_accept;
    logic [DATA_WIDTH-1:0] pix;
    logic [DIM_W-1:0]      km1;
    logic [DIM_W-1:0]      rk;
    logic [DIM_W-1:0]      ck;
    logic [DIM_W-1:0]      hk;
    logic [DIM_W-1:0]      wk;
    int                    k_int;

    assign stall     = win_valid && !win_ready;
    assign issue     = (state_q == StFetch) && !stall;
    assign bram_en   = issue;
    assign bram_addr = addr_q;
    assign pix_vld   = rd_vld_q || hold_vld_q;
    assign pix       = hold_vld_q ? hold_q : bram_din;
    assign consume   = pix_vld && !stall;
    assign k_int     = int'(cfg_k_q);

    assign km1  = DIM_W'(cfg_k_q) - DIM_W'(1);
    assign rk   = proc_row_q - km1;
    assign ck   = proc_col_q - km1;
    assign emit = (proc_row_q >= km1) && (proc_col_q >= km1) && !(cfg_s_q && (rk[0] || ck[0]));
    assign last_accept = win_valid && win_ready && (win_row == last_row_q) &&
                         (win_col == last_col_q);

    assign hk     = img_height - DIM_W'(ker_size);
    assign wk     = img_width - DIM_W'(ker_size);
    assign cfg_ok = (ker_size != 3'd0) && (32'(ker_size) <= KS) &&
                    (img_width != '0) && (img_height != '0) &&
                    (32'(img_width) <= MAX_IMG_WIDTH) && (32'(img_height) <= MAX_IMG_WIDTH) &&
                    (DIM_W'(ker_size) <= img_width) && (DIM_W'(ker_size) <= img_height);

    // Column vector for the current pixel: window row i holds image row r-(K-1-i);
    // line buffer k holds row r-1-k at the same column.
    always_comb begin
        colv  = '0;
        tap_d = '0;
        for (int i = 0; i < KS; i++) begin
            if (i == k_int - 1) colv[i] = pix;
            for (int k = 0; k < NLB; k++) begin
                if (i + k == k_int - 2) colv[i] = lb_q[k][proc_col_q];
            end
        end
        for (int i = 0; i < KS; i++) begin
            for (int j = 0; j < KS - 1; j++) begin
                if (j < k_int - 1 && proc_col_q != '0) tap_d[i][j] = tap_q[i][j+1];
            end
            for (int j = 0; j < KS; j++) begin
                if (j == k_int - 1) tap_d[i][j] = colv[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q <= '0;
            for (int k = 0; k < NLB; k++) begin
                for (int c = 0; c < MAX_IMG_WIDTH; c++) lb_q[k][c] <= '0;
            end
        end else if (consume) begin
            tap_q                <= tap_d;
            lb_q[0][proc_col_q]  <= pix;
            for (int k = 1; k < NLB; k++) lb_q[k][proc_col_q] <= lb_q[k-1][proc_col_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
            frame_done  <= 1'b0;
            cfg_w_q     <= '0;
            cfg_k_q     <= '0;
            cfg_s_q     <= 1'b0;
            last_row_q  <= '0;
            last_col_q  <= '0;
            npix_m1_q   <= '0;
            iss_cnt_q   <= '0;
            addr_q      <= '0;
            rd_vld_q    <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_q      <= '0;
            done_seen_q <= 1'b0;
            proc_row_q  <= '0;
            proc_col_q  <= '0;
            win_valid   <= 1'b0;
            win_data    <= '0;
            win_row     <= '0;
            win_col     <= '0;
        end else begin
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
            rd_vld_q   <= issue;

            // A read returning during a stall is parked and replayed first on release.
            if (rd_vld_q && stall) begin
                hold_vld_q <= 1'b1;
                hold_q     <= bram_din;
            end else if (consume) begin
                hold_vld_q <= 1'b0;
            end

            if (consume) begin
                if (proc_col_q == cfg_w_q - DIM_W'(1)) begin
                    proc_col_q <= '0;
                    proc_row_q <= proc_row_q + DIM_W'(1);
                end else begin
                    proc_col_q <= proc_col_q + DIM_W'(1);
                end
            end

            if (consume && emit) begin
                win_valid <= 1'b1;
                win_data  <= tap_d;
                win_row   <= cfg_s_q ? (rk >> 1) : rk;
                win_col   <= cfg_s_q ? (ck >> 1) : ck;
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start && cfg_ok) begin
                        state_q     <= StFetch;
                        busy        <= 1'b1;
                        cfg_w_q     <= img_width;
                        cfg_k_q     <= ker_size;
                        cfg_s_q     <= stride;
                        last_row_q  <= stride ? (hk >> 1) : hk;
                        last_col_q  <= stride ? (wk >> 1) : wk;
                        npix_m1_q   <= PIX_W'(img_width) * PIX_W'(img_height) - PIX_W'(1);
                        iss_cnt_q   <= '0;
                        addr_q      <= base_addr;
                        proc_row_q  <= '0;
                        proc_col_q  <= '0;
                        done_seen_q <= 1'b0;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                StFetch: begin
                    // With stride 2 the final window can complete before the tail is fetched.
                    if (last_accept) done_seen_q <= 1'b1;
                    if (issue) begin
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        iss_cnt_q <= iss_cnt_q + PIX_W'(1);
                        if (iss_cnt_q == npix_m1_q) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_accept || done_seen_q) begin
                        state_q    <= StIdle;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        rd_vld_q   <= 1'b0;
                        hold_vld_q <= 1'b0;
                        win_valid  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen: BRAM returns its address as data; each presented
// window is compared against a reference built from the pixel-address formula.
module tb_window_stream_gen;
    localparam int DW   = 32;
    localparam int AW   = 12;
    localparam int MW   = 28;
    localparam int KS   = 5;
    localparam int DIMW = 5;

    typedef logic [KS-1:0][KS-1:0][DW-1:0] win_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [DIMW-1:0] img_width;
    logic [DIMW-1:0] img_height;
    logic [2:0]      ker_size;
    logic            stride;
    logic            bram_en;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_din;
    win_t            win_data;
    logic            win_valid;
    logic            win_ready;
    logic [DIMW-1:0] win_row;
    logic [DIMW-1:0] win_col;
    logic            busy;
    logic            frame_done;
    logic            cfg_err;

    int   ncmp  = 0;
    int   nfail = 0;
    win_t first_w, last_w, sel_w, hw;
    int   last_r, last_c, ndone_rst;

    window_stream_gen #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_IMG_WIDTH(MW), .MAX_KERNEL_SIZE(KS),
        .DIM_W(DIMW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .img_width(img_width), .img_height(img_height), .ker_size(ker_size),
        .stride(stride), .bram_en(bram_en), .bram_addr(bram_addr), .bram_din(bram_din),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Output is only meaningful the cycle after a read; otherwise it is junk.
    always @(posedge clk) begin
        if (bram_en) bram_din <= DW'(bram_addr);
        else         bram_din <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input win_t obs, input win_t exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic win_t exp_win(input int w, input int k, input int s, input int base,
                                     input int wr, input int wc);
        win_t v = '0;
        for (int i = 0; i < KS; i++) begin
            for (int j = 0; j < KS; j++) begin
                if (i < k && j < k) v[i][j] = DW'((base + (wr * s + i) * w + wc * s + j) % 4096);
            end
        end
        return v;
    endfunction

    task automatic run_frame(input int w, input int h, input int k, input int s, input int base,
                             input bit rnd, input bit poke, input int exp_done,
                             input int sel_r, input int sel_c);
        int nr, nc, total, nwin, ndone, done_at, cyc, er, ec;
        nr         = (h - k) / s + 1;
        nc         = (w - k) / s + 1;
        total      = nr * nc;
        img_width  = DIMW'(w);
        img_height = DIMW'(h);
        ker_size   = 3'(k);
        stride     = (s == 2);
        base_addr  = AW'(base);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        // Config must already be latched; scramble the inputs.
        img_width  = 5'd1;
        img_height = 5'd31;
        ker_size   = 3'd6;
        stride     = ~stride;
        base_addr  = 12'h5A5;
        nwin = 0; ndone = 0; done_at = -1; cyc = 0;
        chk("busy_rise", busy, 1);
        while (cyc < 5000 && ndone == 0) begin
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (cyc == 3);
            #1;
            if (poke && cyc == 4) chk("start_while_busy", cfg_err, 0);
            if (frame_done) begin
                ndone++;
                done_at = cyc;
                chk("busy_fall", busy, 0);
            end
            if (win_valid) begin
                if (nwin >= total) begin
                    chk("extra_window", nwin, total);
                end else begin
                    er = nwin / nc;
                    ec = nwin % nc;
                    chk("win_row", win_row, er);
                    chk("win_col", win_col, ec);
                    chk_win("win_data", win_data, exp_win(w, k, s, base, er, ec));
                    if (win_ready) begin
                        if (nwin == 0) first_w = win_data;
                        if (er == sel_r && ec == sel_c) sel_w = win_data;
                        last_w = win_data;
                        last_r = int'(win_row);
                        last_c = int'(win_col);
                        nwin++;
                    end else begin
                        chk("stall_bram_en", bram_en, 0);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("window_count", nwin, total);
        chk("frame_done_seen", ndone, 1);
        if (exp_done >= 0) chk("done_cycle", done_at, exp_done);
        repeat (3) begin
            chk("done_once", frame_done, 0);
            @(negedge clk);
        end
    endtask

    task automatic cfg_reject(input int w, input int h, input int k);
        img_width  = DIMW'(w);
        img_height = DIMW'(h);
        ker_size   = 3'(k);
        stride     = 1'b0;
        base_addr  = '0;
        win_ready  = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_busy", busy, 0);
        chk("cfg_bram_en", bram_en, 0);
        @(negedge clk);
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_busy2", busy, 0);
        chk("cfg_bram_en2", bram_en, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bram_en"}, bram_en, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_win_col"}, win_col, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk_win({tag, "_win_data"}, win_data, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; img_width = '0; img_height = '0;
        ker_size = '0; stride = 1'b0; win_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 4x4, K=3, S=1: four windows, frame_done at W*H+2 after busy rises.
        run_frame(4, 4, 3, 1, 0, 1'b0, 1'b0, 18, -1, -1);
        hw = '0;
        hw[0][0] = 0; hw[0][1] = 1; hw[0][2] = 2;
        hw[1][0] = 4; hw[1][1] = 5; hw[1][2] = 6;
        hw[2][0] = 8; hw[2][1] = 9; hw[2][2] = 10;
        chk_win("first_window", first_w, hw);
        chk("last_row", last_r, 1);
        chk("last_col", last_c, 1);
        chk("last_bottom_right", last_w[2][2], 15);

        // 6x6, K=2, S=2: nine windows; window (1,1) covers rows 2..3, cols 2..3.
        run_frame(6, 6, 2, 2, 0, 1'b0, 1'b0, 38, 1, 1);
        hw = '0;
        hw[0][0] = 14; hw[0][1] = 15;
        hw[1][0] = 20; hw[1][1] = 21;
        chk_win("stride2_window_1_1", sel_w, hw);

        // Random backpressure plus a start pulse while busy.
        run_frame(4, 4, 3, 1, 0, 1'b1, 1'b1, -1, -1, -1);

        cfg_reject(4, 4, 6);
        cfg_reject(3, 4, 4);
        cfg_reject(4, 4, 0);
        cfg_reject(0, 4, 1);
        cfg_reject(4, 29, 1);

        // Largest frame.
        run_frame(28, 28, 5, 1, 0, 1'b0, 1'b0, 786, -1, -1);
        chk("big_last_row", last_r, 23);
        chk("big_last_col", last_c, 23);
        chk("big_bottom_right", last_w[4][4], 783);

        // Address wrap past 2^ADDR_WIDTH, and a stride-2 frame whose tail emits nothing.
        run_frame(4, 3, 2, 1, 4090, 1'b0, 1'b0, 14, -1, -1);
        run_frame(5, 5, 2, 2, 0, 1'b0, 1'b0, -1, -1, -1);

        // Reset mid-frame while a window is presented.
        img_width = 5'd4; img_height = 5'd4; ker_size = 3'd3; stride = 1'b0; base_addr = '0;
        win_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_reset_valid", win_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        ndone_rst = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done) ndone_rst++;
        end
        chk("no_done_after_reset", ndone_rst, 0);
        run_frame(4, 4, 3, 1, 0, 1'b0, 1'b0, 18, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
